// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and a REQ/HOLD handshake
// that tolerates a multi-cycle instruction memory and hazard-unit stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic        fetch_busy,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        addr_err_d
);

  localparam logic [0:0] StReq  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  // 33-bit limit so a window ending at 2^32 does not wrap
  localparam logic [32:0] ImemLimit = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d_nx;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc8_q, ifid_pc8_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_err_q, ifid_err_d;
  logic        pc_legal;
  logic [31:0] pc_plus8;

  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= IMEM_BASE) && ({1'b0, pc_q} < ImemLimit);
  assign pc_plus8 = pc_q + 32'd8;

  always_comb begin
    state_d      = state_q;
    pc_d_nx      = pc_q;
    buf_d        = buf_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc8_d   = ifid_pc8_q;
    ifid_valid_d = ifid_valid_q;
    ifid_err_d   = ifid_err_q;
    imem_req     = 1'b0;
    fetch_busy   = 1'b0;

    if (state_q == StReq) begin
      imem_req = pc_legal;
      if (pc_legal) begin
        if (imem_ready) begin
          if (!stall) begin
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = pc_q;
            ifid_pc8_d   = pc_plus8;
            ifid_valid_d = 1'b1;
            ifid_err_d   = 1'b0;
            pc_d_nx      = npc;
          end else begin
            // Word arrived during a stall: park it until the stall releases
            buf_d   = imem_rdata;
            state_d = StHold;
          end
        end else begin
          fetch_busy = 1'b1;
          if (!stall) begin
            ifid_instr_d = 32'd0;
            ifid_pc_d    = 32'd0;
            ifid_pc8_d   = 32'd0;
            ifid_valid_d = 1'b0;
            ifid_err_d   = 1'b0;
          end
        end
      end else if (!stall) begin
        // Illegal PC retires as a marked instruction without touching memory
        ifid_instr_d = 32'd0;
        ifid_pc_d    = pc_q;
        ifid_pc8_d   = pc_plus8;
        ifid_valid_d = 1'b1;
        ifid_err_d   = 1'b1;
        pc_d_nx      = npc;
      end
    end else if (!stall) begin
      ifid_instr_d = buf_q;
      ifid_pc_d    = pc_q;
      ifid_pc8_d   = pc_plus8;
      ifid_valid_d = 1'b1;
      ifid_err_d   = 1'b0;
      pc_d_nx      = npc;
      state_d      = StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      buf_q        <= 32'd0;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_pc8_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d_nx;
      buf_q        <= buf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc8_q   <= ifid_pc8_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_err_q   <= ifid_err_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_f       = pc_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc8_d      = ifid_pc8_q;
  assign valid_d    = ifid_valid_q;
  assign addr_err_d = ifid_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait fetch, wait bubbles, stall capture, illegal PCs,
// redirect and reset during an outstanding fetch.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready;
  logic [31:0] npc, imem_rdata;
  logic        imem_req, fetch_busy, valid_d, addr_err_d;
  logic [31:0] imem_addr, pc_f, instr_d, pc_d, pc8_d;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc       (npc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .pc_f      (pc_f),
    .fetch_busy(fetch_busy),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .valid_d   (valid_d),
    .addr_err_d(addr_err_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] pc8, input logic v, input logic e);
    chk({tag, ".instr"}, instr_d, ins);
    chk({tag, ".pc"}, pc_d, pc);
    chk({tag, ".pc8"}, pc8_d, pc8);
    chk({tag, ".valid"}, 32'(valid_d), 32'(v));
    chk({tag, ".err"}, 32'(addr_err_d), 32'(e));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; npc = 32'd0; imem_rdata = 32'd0;
    tick(); tick();
    chk_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.pc_f", pc_f, 32'h3000);
    chk("reset.req", 32'(imem_req), 32'd1);
    chk("reset.addr", imem_addr, 32'h3000);

    // Zero-wait fetch
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2401_0001; npc = 32'h3004;
    tick();
    chk_ifid("zw1", 32'h2401_0001, 32'h3000, 32'h3008, 1'b1, 1'b0);
    chk("zw1.pc_f", pc_f, 32'h3004);

    // Two wait cycles at 0x3004
    imem_ready = 1'b0; npc = 32'hDEAD_0000;
    for (int i = 0; i < 2; i++) begin
      #1 chk("wait.busy", 32'(fetch_busy), 32'd1);
      tick();
      chk("wait.valid", 32'(valid_d), 32'd0);
      chk("wait.pc_f", pc_f, 32'h3004);
    end
    imem_ready = 1'b1; imem_rdata = 32'h2402_0002; npc = 32'h3008;
    tick();
    chk_ifid("zw2", 32'h2402_0002, 32'h3004, 32'h300C, 1'b1, 1'b0);

    // Ready while stalled: capture to holding buffer, hold for 3 cycles
    stall = 1'b1; imem_rdata = 32'h8C22_0000; npc = 32'hBAD0_0000;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("hold.req", 32'(imem_req), 32'd0);
      chk("hold.busy", 32'(fetch_busy), 32'd0);
      chk("hold.instr", instr_d, 32'h2402_0002);
      chk("hold.pc_f", pc_f, 32'h3008);
      tick();
    end
    chk("hold3.instr", instr_d, 32'h2402_0002);
    stall = 1'b0; npc = 32'h300C;
    tick();
    chk_ifid("release", 32'h8C22_0000, 32'h3008, 32'h3010, 1'b1, 1'b0);
    chk("release.pc_f", pc_f, 32'h300C);
    chk("release.req", 32'(imem_req), 32'd1);

    // Wait while stalled: IF/ID holds rather than bubbling
    stall = 1'b1; imem_ready = 1'b0;
    tick();
    chk("wstall.valid", 32'(valid_d), 32'd1);
    chk("wstall.instr", instr_d, 32'h8C22_0000);

    // Illegal PCs: misaligned, below base, at limit, top of address space
    stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1111_1111; npc = 32'h3002;
    tick();
    chk("ill.pc_f", pc_f, 32'h3002);
    chk("mis.req", 32'(imem_req), 32'd0);
    npc = 32'h2FFC; imem_rdata = 32'h5555_5555;
    tick();
    chk_ifid("mis", 32'd0, 32'h3002, 32'h300A, 1'b1, 1'b1);
    chk("low.req", 32'(imem_req), 32'd0);
    npc = 32'h4000;
    tick();
    chk_ifid("low", 32'd0, 32'h2FFC, 32'h3004, 1'b1, 1'b1);
    chk("lim.req", 32'(imem_req), 32'd0);
    npc = 32'hFFFF_FFFC;
    tick();
    chk_ifid("lim", 32'd0, 32'h4000, 32'h4008, 1'b1, 1'b1);
    stall = 1'b1; npc = 32'h1234_5678;
    tick();
    chk("illstall.pc_f", pc_f, 32'hFFFF_FFFC);
    chk("illstall.pc_d", pc_d, 32'h4000);

    // Wrap of pc+8, then redirect to 0x3100
    stall = 1'b0; npc = 32'h3100;
    tick();
    chk_ifid("wrap", 32'd0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b1);
    chk("redir.addr", imem_addr, 32'h3100);
    chk("redir.req", 32'(imem_req), 32'd1);
    imem_rdata = 32'hAAAA_0001; npc = 32'h3104;
    tick();
    chk_ifid("redir", 32'hAAAA_0001, 32'h3100, 32'h3108, 1'b1, 1'b0);

    // Reset during an outstanding fetch, ready in the reset cycle is discarded
    imem_ready = 1'b0;
    tick();
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBBBB_0002; npc = 32'h5555_0000;
    tick();
    chk("rst2.pc_f", pc_f, 32'h3000);
    chk("rst2.valid", 32'(valid_d), 32'd0);
    chk("rst2.instr", instr_d, 32'd0);
    reset = 1'b0; imem_rdata = 32'hCCCC_0003; npc = 32'h3004;
    tick();
    chk_ifid("postrst", 32'hCCCC_0003, 32'h3000, 32'h3008, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the next-PC value produced by the D-stage next-PC logic and drives the instruction-memory request.
- Tolerates a multi-cycle instruction memory through a small request/ready state machine and a one-word holding buffer, and honours hazard-unit stalls.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset
IMEM_BASE, 32'h00003000, lowest legal instruction address
IMEM_WORDS, 1024, number of legal instruction words from IMEM_BASE

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; freezes PC and IF/ID
npc  input  32  next PC from next-PC logic, taken when the current fetch retires
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (= pc_f)
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory completion; may be high in the same cycle as imem_req; ignored while imem_req=0
pc_f  output  32  current PC register value
fetch_busy  output  1  high while a legal fetch is outstanding and not yet returned
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
pc8_d  output  32  IF/ID PC+8 (link address)
valid_d  output  1  IF/ID holds a real instruction
addr_err_d  output  1  IF/ID instruction came from an illegal PC

Behaviour:
- Reset:
  - pc_f=RESET_PC; state=REQ.
  - Holding buffer empty.
  - instr_d=0, pc_d=0, pc8_d=0, valid_d=0, addr_err_d=0.
  - Reset wins over stall and any outstanding fetch; a ready arriving in the reset cycle is discarded.
- Illegal PC: pc_f[1:0]!=0, pc_f<IMEM_BASE, or pc_f>=IMEM_BASE+4*IMEM_WORDS. Comparisons are unsigned 32-bit.
- State REQ:
  - imem_req=1 if PC is legal, else 0. imem_addr=pc_f always.
  - Legal PC, imem_ready=1, stall=0: IF/ID <= {imem_rdata, pc_f, pc_f+8, valid=1, err=0}; pc_f <= npc; stay REQ.
  - Legal PC, imem_ready=1, stall=1: word -> holding buffer; IF/ID and PC hold; go HOLD.
  - Legal PC, imem_ready=0: fetch_busy=1. If stall=0, IF/ID <= bubble (all zero). If stall=1, IF/ID holds. PC holds; stay REQ.
  - Illegal PC, stall=0: IF/ID <= {0, pc_f, pc_f+8, valid=1, err=1}; pc_f <= npc. No memory access is made.
  - Illegal PC, stall=1: everything holds.
- State HOLD:
  - imem_req=0, fetch_busy=0.
  - stall=1: everything holds.
  - stall=0: IF/ID <= buffer contents (valid=1); pc_f <= npc; go REQ.
- Latency: zero-wait memory gives one instruction per cycle, fetched at cycle n and visible on the *_d outputs at cycle n+1. Each wait cycle inserts exactly one bubble (when unstalled).
- Arithmetic: pc8_d = pc+8 modulo 2^32 (0xFFFFFFFC+8 = 0x00000004).
- npc is sampled only on the edge where the fetch retires. Its value in other cycles is ignored.
- No flush input: the branch delay slot is always fetched and kept.

Test Plan:
- Reset then release, zero-wait memory returning 0x24010001, 0x24020002 → cycle 1: valid_d=1, instr_d=0x24010001, pc_d=0x3000, pc8_d=0x3008; cycle 2: instr_d=0x24020002, pc_d=0x3004.
- imem_ready low for 2 cycles at pc_f=0x3004, stall=0 → two bubbles (valid_d=0, fetch_busy=1), pc_f stays 0x3004, then the instruction appears with pc_d=0x3004.
- Ready with word 0x8C220000 while stall=1 for 3 cycles → IF/ID unchanged, imem_req=0 after capture, pc_f constant; first cycle after stall drops: instr_d=0x8C220000 and pc_f=npc.
- npc=0x00003002 → next cycle imem_req=0; following edge: valid_d=1, addr_err_d=1, instr_d=0, pc_d=0x3002. Repeat with npc=0x00002FFC and npc=IMEM_BASE+4*IMEM_WORDS: same response.
- reset asserted while a fetch is waiting (imem_ready=0) and ready asserted in the same cycle → word discarded, pc_f=0x3000, valid_d=0, state REQ.
- Branch redirect: npc=0x00003100 at the retire edge of the delay slot → next fetch imem_addr=0x3100.
